// File: rtl/bictr_pkg.sv
// bictr_pkg: shared FSM encoding and load polarity for the counter controller
package bictr_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
   localparam logic LOAD_ACTIVE = 1'b0;
endpackage

// File: rtl/bictr_dcnto_ctrl_if.sv
// bictr_dcnto_ctrl_if: command/response handshake bundle of the counter controller
interface bictr_dcnto_ctrl_if #(parameter int WIDTH = 4);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_start;
   logic [WIDTH-1:0] cmd_target;
   logic             cmd_up;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_count;
   logic [WIDTH-1:0] rsp_steps;
   logic             rsp_abort;
   logic             rsp_err;
   modport master (
      output cmd_valid, cmd_start, cmd_target, cmd_up, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_count, rsp_steps, rsp_abort, rsp_err
   );
   modport slave (
      input  cmd_valid, cmd_start, cmd_target, cmd_up, rsp_ready,
      output cmd_ready, rsp_valid, rsp_count, rsp_steps, rsp_abort, rsp_err
   );
endinterface

// File: rtl/bictr_sat_cnt.sv
// bictr_sat_cnt: saturating up-counter with clear and enable
module bictr_sat_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);
   logic [W-1:0] cnt_q, cnt_d;
   // clear beats enable; the count sticks at all-ones
   always_comb cnt_d = clr ? '0 : (en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign q = cnt_q;
endmodule

// File: rtl/bictr_dcnto_ctrl.sv
// bictr_dcnto_ctrl: run-command driver for the up/down count-to counter; BICTR_CTRL_TIMEOUT_EN adds a RUN watchdog
import bictr_pkg::*;
module bictr_dcnto_ctrl #(
   parameter int WIDTH       = 4,
   parameter int TIMEOUT_CYC = 2**WIDTH + 2
) (
   input  logic              clk,
   input  logic              reset,
   bictr_dcnto_ctrl_if.slave bus,
   input  logic              abort,
   output logic              load,
   output logic              cen,
   output logic              up_dn,
   output logic [WIDTH-1:0]  data,
   output logic [WIDTH-1:0]  count_to,
   input  logic              tercnt,
   input  logic [WIDTH-1:0]  count
);
   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic [WIDTH-1:0] steps;
      logic             abort;
      logic             err;
   } rsp_t;
   state_e           state_q, state_d;
   logic             load_q, load_d, up_dn_q, up_dn_d, rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] data_q, data_d, count_to_q, count_to_d, steps;
   rsp_t             rsp_q, rsp_d;
   logic             accept, run, timeout;
   assign run           = state_q == RUN;
   assign bus.cmd_ready = (state_q == IDLE) & reset;
   assign accept        = bus.cmd_valid & bus.cmd_ready;
   assign cen           = run & ~tercnt & ~abort & ~timeout;
   bictr_sat_cnt #(.W(WIDTH)) u_steps (
      .clk(clk), .reset(reset), .clr(accept), .en(cen), .q(steps)
   );
`ifdef BICTR_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd;
   bictr_sat_cnt #(.W(WD_W)) u_wd (
      .clk(clk), .reset(reset), .clr(!run), .en(run), .q(wd)
   );
   assign timeout = run && wd == WD_W'(TIMEOUT_CYC - 1);
`else
   assign timeout = 1'b0;
`endif
   // next state; the response is captured on the RUN exit, tercnt beating abort beating the watchdog
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      count_to_d = count_to_q;
      up_dn_d    = up_dn_q;
      rsp_d      = rsp_q;
      if (accept) begin
         state_d    = LOAD;
         data_d     = bus.cmd_start;
         count_to_d = bus.cmd_target;
         up_dn_d    = bus.cmd_up;
      end else if (state_q == LOAD) state_d = RUN;
      else if (run && (tercnt || abort || timeout)) begin
         state_d = DONE;
         rsp_d   = '{count, steps, ~tercnt & abort, ~tercnt & ~abort & timeout};
      end else if (state_q == DONE && bus.rsp_ready) state_d = IDLE;
      load_d      = (state_d == LOAD) ? LOAD_ACTIVE : ~LOAD_ACTIVE;
      rsp_valid_d = state_d == DONE;
   end
   // FSM and registered outputs
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q     <= IDLE;
         load_q      <= ~LOAD_ACTIVE;
         up_dn_q     <= 1'b1;
         data_q      <= '0;
         count_to_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         load_q      <= load_d;
         up_dn_q     <= up_dn_d;
         data_q      <= data_d;
         count_to_q  <= count_to_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   assign load          = load_q;
   assign up_dn         = up_dn_q;
   assign data          = data_q;
   assign count_to      = count_to_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_count = rsp_q.count;
   assign bus.rsp_steps = rsp_q.steps;
   assign bus.rsp_abort = rsp_q.abort;
   assign bus.rsp_err   = rsp_q.err;
endmodule
